// File: rtl/add_arbiter_if.sv
// Two-requester add/subtract bus: request side, shared response side and the saturation counter.
// Handshake: an operation transfers on a cycle where req_valid[i] && req_ready[i]; a result
// transfers on a cycle where rsp_valid[i] && rsp_ready[i]. Valid never waits on ready.
interface add_arbiter_if #(
  parameter int DATA_WIDTH = 16
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [2*DATA_WIDTH-1:0] req_a;
  logic [2*DATA_WIDTH-1:0] req_b;
  logic [1:0]              req_sub;
  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_sum;
  logic                    rsp_ovf;
  logic                    rsp_unf;
  logic [15:0]             sat_count;

  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_ovf, rsp_unf, sat_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_ovf, rsp_unf, sat_count
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter in front of a single signed adder/subtractor with optional saturation.
// One operation is owned from acceptance until its result is taken (IDLE -> CALC -> RESP).
module add_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int FIXED_PNT  = 8,
  parameter int SATURATE   = 1
) (
  input  logic         clk,
  input  logic         rst,
  add_arbiter_if.slave bus,
  output logic [1:0]   o_dbg_state
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  if (FIXED_PNT < 0 || FIXED_PNT > DATA_WIDTH) begin : g_bad_fixed_pnt
    $error("add_arbiter: FIXED_PNT must lie within 0..DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_last_grant;
  logic           r_grant;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_sub;
  logic [W-1:0]   r_sum;
  logic           r_ovf;
  logic           r_unf;
  logic [15:0]    r_sat_count;

  logic           w_gnt;
  logic           w_accept;
  logic [1:0]     w_req_ready;
  logic [1:0]     w_rsp_valid;
  logic           w_release;
  logic [W:0]     w_a_ext;
  logic [W:0]     w_b_ext;
  logic [W:0]     w_full;
  logic           w_ovf;
  logic           w_unf;
  logic [W-1:0]   w_sum;

  // With both requesting, the one not served last wins; a lone requester always wins.
  always_comb begin
    w_gnt = 1'b0;
    case (bus.req_valid)
      2'b01:   w_gnt = 1'b0;
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = ~r_last_grant;
      default: w_gnt = 1'b0;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_req_ready = 2'b00;
    w_rsp_valid = 2'b00;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|bus.req_valid && !rst) begin
          w_accept    = 1'b1;
          w_req_ready = w_gnt ? 2'b10 : 2'b01;
          w_next      = S_CALC;
        end
      end
      S_CALC: w_next = S_RESP;
      S_RESP: begin
        w_rsp_valid = r_grant ? 2'b10 : 2'b01;
        if (bus.rsp_ready[r_grant]) begin
          w_release = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // One extra bit of headroom holds the exact sum/difference of two W-bit signed operands.
  always_comb begin
    w_a_ext = {r_a[W-1], r_a};
    w_b_ext = {r_b[W-1], r_b};
    w_full  = r_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
    w_ovf   = ~w_full[W] &  w_full[W-1];
    w_unf   =  w_full[W] & ~w_full[W-1];
    w_sum   = w_full[W-1:0];
    if (SATURATE != 0) begin
      if (w_ovf)      w_sum = MAX_VAL;
      else if (w_unf) w_sum = MIN_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_sub        <= 1'b0;
      r_sum        <= '0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_sat_count  <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_grant <= w_gnt;
        r_a     <= w_gnt ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
        r_b     <= w_gnt ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
        r_sub   <= w_gnt ? bus.req_sub[1] : bus.req_sub[0];
      end
      if (r_state == S_CALC) begin
        r_sum <= w_sum;
        r_ovf <= w_ovf;
        r_unf <= w_unf;
        if (w_ovf || w_unf) r_sat_count <= r_sat_count + 16'd1;
      end
      if (w_release) r_last_grant <= r_grant;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_sum   = r_sum;
  assign bus.rsp_ovf   = r_ovf;
  assign bus.rsp_unf   = r_unf;
  assign bus.sat_count = r_sat_count;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: saturating and wrapping instances share stimulus and are checked each
// cycle against an arithmetic model of arbitration, latency and results.
module tb_add_arbiter;
  localparam int DW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  add_arbiter_if #(.DATA_WIDTH(DW)) wbus ();
  logic [1:0] dbg_s;
  logic [1:0] dbg_w;

  add_arbiter #(.DATA_WIDTH(DW), .FIXED_PNT(8), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_s)
  );
  add_arbiter #(.DATA_WIDTH(DW), .FIXED_PNT(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .bus(wbus), .o_dbg_state(dbg_w)
  );

  assign wbus.req_valid = bus.req_valid;
  assign wbus.req_a     = bus.req_a;
  assign wbus.req_b     = bus.req_b;
  assign wbus.req_sub   = bus.req_sub;
  assign wbus.rsp_ready = bus.rsp_ready;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact integer result, then clamp or wrap to DW bits.
  function automatic void model_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic sub, output logic [DW-1:0] s_sat,
                                   output logic [DW-1:0] s_wrap, output logic o,
                                   output logic u);
    int ia, ib, t, maxv, minv;
    logic [31:0] tv;
    ia   = $signed(a);
    ib   = $signed(b);
    maxv = (1 << (DW-1)) - 1;
    minv = -(1 << (DW-1));
    t    = sub ? (ia - ib) : (ia + ib);
    o    = (t > maxv);
    u    = (t < minv);
    tv   = t;
    s_wrap = tv[DW-1:0];
    s_sat  = o ? maxv[DW-1:0] : (u ? minv[DW-1:0] : tv[DW-1:0]);
  endfunction

  // scoreboard
  typedef struct {
    int             req;
    logic [DW-1:0]  sum;
    logic [DW-1:0]  wsum;
    logic           ovf;
    logic           unf;
    logic           flag;
    int             acc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc      = 0;
  int          m_last   = 1;
  logic [15:0] m_sat    = 16'd0;
  bit          just_rst = 1'b0;

  always @(negedge clk) begin
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_rv;
    logic [15:0] exp_sat;
    int          g;
    bit          vis;
    exp_t        e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_last   = 1;
      m_sat    = 16'd0;
      just_rst = 1'b1;
      check("req_ready_in_rst", bus.req_ready, 2'b00);
    end else begin
      if (just_rst) begin
        check("rst_rsp_sum", bus.rsp_sum, 16'h0000);
        check("rst_rsp_ovf", bus.rsp_ovf, 1'b0);
        check("rst_rsp_unf", bus.rsp_unf, 1'b0);
        check("rst_sat_count", bus.sat_count, 16'h0000);
        check("rst_state", dbg_s, 2'd0);
        check("rst_state_w", dbg_w, 2'd0);
        just_rst = 1'b0;
      end
      exp_rdy = 2'b00;
      g = -1;
      if (exp_q.size() == 0 && bus.req_valid != 2'b00) begin
        if (bus.req_valid == 2'b11) g = (m_last == 0) ? 1 : 0;
        else                        g = bus.req_valid[1] ? 1 : 0;
        exp_rdy = (g == 1) ? 2'b10 : 2'b01;
      end
      check("req_ready", bus.req_ready, exp_rdy);
      check("req_ready_w", wbus.req_ready, exp_rdy);

      vis    = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
      exp_rv = vis ? ((exp_q[0].req == 1) ? 2'b10 : 2'b01) : 2'b00;
      check("rsp_valid", bus.rsp_valid, exp_rv);
      check("rsp_valid_w", wbus.rsp_valid, exp_rv);

      exp_sat = m_sat;
      if (exp_q.size() > 0 && !vis && exp_q[0].flag) exp_sat = m_sat - 16'd1;
      check("sat_count", bus.sat_count, exp_sat);
      check("sat_count_w", wbus.sat_count, exp_sat);

      if (vis) begin
        check("rsp_sum", bus.rsp_sum, exp_q[0].sum);
        check("rsp_ovf", bus.rsp_ovf, exp_q[0].ovf);
        check("rsp_unf", bus.rsp_unf, exp_q[0].unf);
        check("rsp_sum_w", wbus.rsp_sum, exp_q[0].wsum);
        check("rsp_ovf_w", wbus.rsp_ovf, exp_q[0].ovf);
        check("rsp_unf_w", wbus.rsp_unf, exp_q[0].unf);
        if (bus.rsp_ready[exp_q[0].req]) begin
          m_last = exp_q[0].req;
          void'(exp_q.pop_front());
        end
      end

      if (g >= 0) begin
        e.req = g;
        e.acc = cyc;
        model_op(bus.req_a[g*DW +: DW], bus.req_b[g*DW +: DW], bus.req_sub[g],
                 e.sum, e.wsum, e.ovf, e.unf);
        e.flag = e.ovf | e.unf;
        exp_q.push_back(e);
        if (e.flag) m_sat = m_sat + 16'd1;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_op(input string tag, input int r, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic sub, input int stall,
                       input logic [DW-1:0] lit_sum, input logic lit_ovf, input logic lit_unf,
                       input logic [DW-1:0] lit_wsum, input logic [15:0] lit_sat);
    bit ok;
    int other;
    other = 1 - r;
    @(posedge clk); #1;
    bus.req_a[r*DW +: DW] = a;
    bus.req_b[r*DW +: DW] = b;
    bus.req_sub[r]        = sub;
    bus.req_valid[r]      = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready[r]) begin ok = 1'b1; break; end
    end
    check({tag, "_accepted"}, ok, 1'b1);
    @(posedge clk); #1;
    bus.req_valid[r] = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid[r]) begin ok = 1'b1; break; end
    end
    check({tag, "_responded"}, ok, 1'b1);
    check({tag, "_sum"}, bus.rsp_sum, lit_sum);
    check({tag, "_ovf"}, bus.rsp_ovf, lit_ovf);
    check({tag, "_unf"}, bus.rsp_unf, lit_unf);
    check({tag, "_wrap_sum"}, wbus.rsp_sum, lit_wsum);
    check({tag, "_sat_count"}, bus.sat_count, lit_sat);
    // While stalled, poke the other requester's ready/valid; neither may disturb the owner.
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      bus.rsp_ready[other] = 1'b1;
      bus.req_valid[other] = (i % 2 == 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready[other] = 1'b0;
    bus.req_valid[other] = 1'b0;
    bus.rsp_ready[r]     = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready[r] = 1'b0;
    @(negedge clk);
    check({tag, "_released"}, bus.rsp_valid, 2'b00);
  endtask

  task automatic rst_calc_test();
    bit ok;
    @(posedge clk); #1;
    bus.req_a[DW +: DW] = 16'h7FFF;
    bus.req_b[DW +: DW] = 16'h0001;
    bus.req_sub[1]      = 1'b0;
    bus.req_valid[1]    = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready[1]) begin ok = 1'b1; break; end
    end
    check("rstcalc_accepted", ok, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstcalc_rsp_valid", bus.rsp_valid, 2'b00);
    check("rstcalc_req_ready", bus.req_ready, 2'b00);
    check("rstcalc_sum", bus.rsp_sum, 16'h0000);
    check("rstcalc_ovf", bus.rsp_ovf, 1'b0);
    check("rstcalc_sat_count", bus.sat_count, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstcalc_no_rsp", bus.rsp_valid, 2'b00);
    end
  endtask

  task automatic rr_test();
    int grants[4];
    int exp_g[4];
    int n;
    exp_g = '{0, 1, 0, 1};
    grants = '{-1, -1, -1, -1};
    do_reset();
    @(posedge clk); #1;
    bus.req_a     = {16'd5, 16'd1};
    bus.req_b     = {16'd3, 16'd2};
    bus.req_sub   = 2'b10;
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (bus.req_ready == 2'b01) begin grants[n] = 0; n++; end
      else if (bus.req_ready == 2'b10) begin grants[n] = 1; n++; end
    end
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1 bus.rsp_ready = 2'b00;
    check("rr_grant_count", n, 4);
    for (int k = 0; k < 4; k++) check($sformatf("rr_grant%0d", k), grants[k], exp_g[k]);
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = 2'b00;
    bus.rsp_ready = 2'b00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_op("add_basic", 0, 16'h0180, 16'h0240, 1'b0, 0, 16'h03C0, 1'b0, 1'b0, 16'h03C0, 16'd0);
    do_op("add_ovf",   1, 16'h7000, 16'h2000, 1'b0, 1, 16'h7FFF, 1'b1, 1'b0, 16'h9000, 16'd1);
    do_op("sub_unf",   0, 16'h8000, 16'h0001, 1'b1, 0, 16'h8000, 1'b0, 1'b1, 16'h7FFF, 16'd2);
    do_op("sub_ovf",   0, 16'h0001, 16'h8000, 1'b1, 0, 16'h7FFF, 1'b1, 1'b0, 16'h8001, 16'd3);
    do_op("sub_stall", 1, 16'h1234, 16'h0FFF, 1'b1, 5, 16'h0235, 1'b0, 1'b0, 16'h0235, 16'd3);
    do_op("add_neg",   0, 16'hFF00, 16'h0080, 1'b0, 2, 16'hFF80, 1'b0, 1'b0, 16'hFF80, 16'd3);
    do_op("sub_mixed", 1, 16'h0010, 16'hFFF0, 1'b1, 0, 16'h0020, 1'b0, 1'b0, 16'h0020, 16'd3);
    do_op("add_unf",   0, 16'h8000, 16'hFFFF, 1'b0, 0, 16'h8000, 1'b0, 1'b1, 16'h7FFF, 16'd4);

    rst_calc_test();
    rr_test();

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, operand/result width in bits.
REQ-002 The block SHALL have parameter FIXED_PNT, default 8, fractional bits; informational only, arithmetic is format-agnostic.
REQ-003 The block SHALL have parameter SATURATE, default 1; 1 = clamp on overflow/underflow, 0 = wrap.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  2  bit i = requester i presents an operation.
REQ-008 req_ready  output  2  bit i = operation of requester i accepted this cycle.
REQ-009 req_a  input  2*DATA_WIDTH  signed operand A; slice i belongs to requester i.
REQ-010 req_b  input  2*DATA_WIDTH  signed operand B; slice i belongs to requester i.
REQ-011 req_sub  input  2  bit i: 1 = A-B, 0 = A+B.
REQ-012 rsp_valid  output  2  bit i = result for requester i available.
REQ-013 rsp_ready  input  2  bit i = requester i takes its result.
REQ-014 rsp_sum  output  DATA_WIDTH  signed result, shared by both requesters.
REQ-015 rsp_ovf  output  1  positive overflow flag of the presented result.
REQ-016 rsp_unf  output  1  negative overflow (underflow) flag of the presented result.
REQ-017 sat_count  output  16  count of results with ovf or unf set; wraps 0xFFFF->0x0000.

Function
REQ-018 The FSM SHALL have states IDLE, CALC, RESP; exactly one requester is owned from IDLE exit to RESP exit.
REQ-019 IDLE: if any req_valid bit is set, grant g is chosen round-robin; req_ready[g]=1 for that single cycle (combinational from state and valid); operands/op latched; next state CALC.
REQ-020 Round-robin: with both valid, grant goes to the requester other than last_grant; with one valid, that one wins regardless of last_grant.
REQ-021 req_ready SHALL be 0 in CALC and RESP, and never have both bits set.
REQ-022 CALC: compute full-precision A+B or A-B; register rsp_sum, rsp_ovf, rsp_unf; next state RESP.
REQ-023 ovf SHALL be set iff the true result > 2^(DATA_WIDTH-1)-1; unf iff it is < -2^(DATA_WIDTH-1); sign rules must be correct for subtraction (A>=0, B<0, result<0 is ovf).
REQ-024 With SATURATE=1, ovf forces rsp_sum=0x7FFF-pattern max, unf forces min (0x8000 at width 16); with SATURATE=0, rsp_sum is the wrapped low DATA_WIDTH bits; flags are reported in both modes.
REQ-025 sat_count SHALL increment by 1 on the CALC cycle whose result has ovf or unf set.
REQ-026 RESP: rsp_valid[g]=1, other bit 0; rsp_sum/flags stable; on rsp_ready[g]=1, last_grant<=g and next state IDLE.
REQ-027 rsp_ready on the non-granted bit, and req_valid changes during CALC/RESP, SHALL have no effect.
REQ-028 Latency: accept in cycle t, rsp_valid high from cycle t+2; minimum 3 cycles per operation.

Reset
REQ-029 On rst: state IDLE, req_ready=0, rsp_valid=0, rsp_sum=0, rsp_ovf=0, rsp_unf=0, sat_count=0, last_grant=1 (requester 0 wins first tie).
REQ-030 rst in CALC or RESP SHALL discard the transaction; no response is ever issued for it.
REQ-031 rst has priority over every other event in the same cycle.

Verification
REQ-032 Req0 A=0x0180, B=0x0240, add -> req_ready[0] one cycle, rsp_valid[0] two cycles later, rsp_sum=0x03C0, flags 0.
REQ-033 Req1 A=0x7000, B=0x2000, add, SATURATE=1 -> rsp_sum=0x7FFF, ovf=1, sat_count=1; SATURATE=0 -> 0x9000, ovf=1.
REQ-034 Req0 A=0x8000, B=0x0001, sub -> rsp_sum=0x8000, unf=1; A=0x0001, B=0x8000, sub -> 0x7FFF, ovf=1.
REQ-035 Both req_valid held high after reset -> grants 0,1,0,1 on consecutive operations; never two ready bits at once.
REQ-036 rsp_ready[g] low 5 cycles -> rsp_valid[g], rsp_sum, flags stable, req_ready stays 0; released -> IDLE next cycle.
REQ-037 rst asserted during CALC -> next cycle all outputs at reset values, no rsp_valid, sat_count=0.
